// File: rtl/quad_pkg.sv
// Shared constants, types and helpers for the quad rasterizer span writer.
package quad_pkg;

  localparam int WARP_WIDTH    = 320;
  localparam int WORD_PIX      = 16;
  localparam int COLOR_W       = 4;
  localparam int WORDS_PER_ROW = WARP_WIDTH / WORD_PIX;
  localparam int SCREEN_ROWS   = 240;
  localparam int ADDR_W        = 13;
  localparam int ROW_Y_W       = 10;

  typedef logic [WORD_PIX*COLOR_W-1:0] pix_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } span_state_t;

  function automatic pix_word_t fill_word(input logic [COLOR_W-1:0] color);
    return {WORD_PIX{color}};
  endfunction

endpackage

// File: rtl/quad_span_writer_if.sv
// Row-in / framebuffer-write-out bundle of the span writer.
// slave = the span writer itself; master = rasterizer plus framebuffer port.
interface quad_span_writer_if #(
  parameter int WARP_WIDTH = quad_pkg::WARP_WIDTH,
  parameter int WORD_PIX   = quad_pkg::WORD_PIX,
  parameter int COLOR_W    = quad_pkg::COLOR_W,
  parameter int ADDR_W     = quad_pkg::ADDR_W
) ();

  logic                        row_valid;
  logic                        row_ready;
  logic [9:0]                  row_y;
  logic [WARP_WIDTH-1:0]       row_mask;
  logic [COLOR_W-1:0]          row_color;
  logic                        mem_valid;
  logic                        mem_ready;
  logic [ADDR_W-1:0]           mem_addr;
  logic [WORD_PIX*COLOR_W-1:0] mem_data;
  logic [WORD_PIX-1:0]         mem_pmask;
  logic                        row_done;

  modport master (
    output row_valid, row_y, row_mask, row_color, mem_ready,
    input  row_ready, mem_valid, mem_addr, mem_data, mem_pmask, row_done
  );

  modport slave (
    input  row_valid, row_y, row_mask, row_color, mem_ready,
    output row_ready, mem_valid, mem_addr, mem_data, mem_pmask, row_done
  );

endinterface

// File: rtl/mask_word_select.sv
// Picks the WORD_PIX-wide slice of the row coverage mask addressed by word index w.
module mask_word_select #(
  parameter int WARP_WIDTH = 320,
  parameter int WORD_PIX   = 16,
  parameter int WIDX_W     = 5
) (
  input  logic [WARP_WIDTH-1:0] mask,
  input  logic [WIDX_W-1:0]     w,
  output logic [WORD_PIX-1:0]   slice,
  output logic                  nonzero
);

  localparam int WORDS = WARP_WIDTH / WORD_PIX;

  // NOTE: default assignment first so every path writes slice; otherwise a latch is inferred.
  always_comb begin
    slice = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (w == WIDX_W'(i)) slice = mask[i*WORD_PIX +: WORD_PIX];
    end
  end

  assign nonzero = |slice;

endmodule

// File: rtl/quad_span_writer.sv
// Serialises one row of quad coverage into 16-pixel masked framebuffer writes.
// Define QUAD_SPAN_SKIP_EMPTY_EN to suppress writes for words with no covered pixel.
module quad_span_writer #(
  parameter int WARP_WIDTH  = quad_pkg::WARP_WIDTH,
  parameter int WORD_PIX    = quad_pkg::WORD_PIX,
  parameter int COLOR_W     = quad_pkg::COLOR_W,
  parameter int SCREEN_ROWS = quad_pkg::SCREEN_ROWS,
  parameter int ADDR_W      = quad_pkg::ADDR_W
) (
  input logic               Clk,
  input logic               Reset,
  quad_span_writer_if.slave bus
);

  import quad_pkg::*;

  localparam int WORDS  = WARP_WIDTH / WORD_PIX;
  localparam int WIDX_W = $clog2(WORDS);
  localparam int Y_W    = 10;

`ifdef QUAD_SPAN_SKIP_EMPTY_EN
  localparam bit SKIP_EMPTY = 1'b1;
`else
  localparam bit SKIP_EMPTY = 1'b0;
`endif

  span_state_t           state_q, state_d;
  logic [WARP_WIDTH-1:0] mask_q;
  logic [COLOR_W-1:0]    color_q;
  logic [Y_W-1:0]        y_q;
  logic [WIDX_W-1:0]     w_q;
  logic [ADDR_W-1:0]     base_q;
  logic                  drop_q;

  logic [WORD_PIX-1:0]   slice;
  logic                  slice_nz;
  logic                  write_req;
  logic                  word_done;
  logic                  word_last;
  logic [Y_W+4:0]        y_ext;

  mask_word_select #(
    .WARP_WIDTH (WARP_WIDTH),
    .WORD_PIX   (WORD_PIX),
    .WIDX_W     (WIDX_W)
  ) u_sel (
    .mask    (mask_q),
    .w       (w_q),
    .slice   (slice),
    .nonzero (slice_nz)
  );

  assign write_req = slice_nz || !SKIP_EMPTY;
  assign word_done = !write_req || bus.mem_ready;
  assign word_last = (w_q == WIDX_W'(WORDS - 1));
  assign y_ext     = {5'd0, y_q};

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.row_valid) state_d = SETUP;
      SETUP:   state_d = SCAN;
      SCAN:    if (drop_q || (word_done && word_last)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the row mask is a plain flop array, not RAM, so it takes a reset value like any register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mask_q  <= '0;
      color_q <= '0;
      y_q     <= '0;
      w_q     <= '0;
      base_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.row_valid) begin
            mask_q  <= bus.row_mask;
            color_q <= bus.row_color;
            y_q     <= bus.row_y;
            w_q     <= '0;
          end
        end
        SETUP: begin
          // y*20 as y*16 + y*4; only rows below SCREEN_ROWS ever use it.
          base_q <= ADDR_W'((y_ext << 4) + (y_ext << 2));
          drop_q <= (y_q >= Y_W'(SCREEN_ROWS));
        end
        SCAN: begin
          if (!drop_q && word_done && !word_last) w_q <= w_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; mem_ready never reaches mem_valid.
  always_comb begin
    bus.row_ready = 1'b0;
    bus.row_done  = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_data  = '0;
    bus.mem_pmask = '0;
    unique case (state_q)
      IDLE: bus.row_ready = 1'b1;
      DONE: bus.row_done  = 1'b1;
      SCAN: begin
        if (!drop_q && write_req) begin
          bus.mem_valid = 1'b1;
          bus.mem_addr  = base_q + ADDR_W'(w_q);
          bus.mem_data  = {WORD_PIX{color_q}};
          bus.mem_pmask = slice;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_quad_span_writer.sv
// Self-checking bench for quad_span_writer: directed rows, a mid-row reset, then random rows.
module tb_quad_span_writer;

  import quad_pkg::*;

`ifdef QUAD_SPAN_SKIP_EMPTY_EN
  localparam bit SKIP_EMPTY = 1'b1;
`else
  localparam bit SKIP_EMPTY = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    pix_word_t           data;
    logic [WORD_PIX-1:0] pmask;
  } wr_t;

  logic clk;
  logic rst;

  quad_span_writer_if bus ();

  quad_span_writer dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  wr_t got_q[$];
  bit  rdy_pat[0:511];
  int  exp_done;
  int  got_done;
  int  done_pulses;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: low on even cycles after acceptance, 2: random.
  task automatic set_ready(input int mode);
    for (int j = 0; j < 512; j++) begin
      case (mode)
        0:       rdy_pat[j] = 1'b1;
        1:       rdy_pat[j] = (j % 2 == 1);
        default: rdy_pat[j] = (j < 300) ? ($urandom_range(0, 1) == 1) : 1'b1;
      endcase
    end
  endtask

  // Reference: which words get written, and in which cycle after acceptance row_done appears.
  task automatic model_row(input logic [9:0] y, input logic [WARP_WIDTH-1:0] mask,
                           input logic [COLOR_W-1:0] color);
    int t;
    logic [WORD_PIX-1:0] sl;
    wr_t wr;
    exp_q.delete();
    if (int'(y) >= SCREEN_ROWS) begin
      exp_done = 3;
      return;
    end
    t = 2;
    for (int w = 0; w < WORDS_PER_ROW; w++) begin
      sl = mask[w*WORD_PIX +: WORD_PIX];
      if (SKIP_EMPTY && sl == '0) begin
        t++;
        continue;
      end
      wr.addr  = ADDR_W'(int'(y) * WORDS_PER_ROW + w);
      wr.data  = {WORD_PIX{color}};
      wr.pmask = sl;
      exp_q.push_back(wr);
      while (!rdy_pat[t]) t++;
      t++;
    end
    exp_done = t;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.row_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("row_ready_wait", 64'(bus.row_ready), 64'd1);
  endtask

  task automatic run_row(input logic [9:0] y, input logic [WARP_WIDTH-1:0] mask,
                         input logic [COLOR_W-1:0] color, input int mode);
    bit  stalled;
    wr_t held;
    wr_t wr;
    int  n;
    set_ready(mode);
    model_row(y, mask, color);
    wait_idle();
    bus.row_valid = 1'b1;
    bus.row_y     = y;
    bus.row_mask  = mask;
    bus.row_color = color;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    got_q.delete();
    got_done    = -1;
    done_pulses = 0;
    stalled     = 1'b0;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      // A second row offered while busy must be ignored.
      bus.row_valid = (j <= 2);
      bus.row_y     = 10'd7;
      bus.row_mask  = ~mask;
      bus.mem_ready = rdy_pat[j];
      if (j <= 2) check("row_ready_busy", 64'(bus.row_ready), 64'd0);
      if (got_done >= 0) begin
        check("row_ready_after_done", 64'(bus.row_ready), 64'd1);
        check("no_write_after_done", 64'(bus.mem_valid), 64'd0);
        break;
      end
      if (stalled) begin
        check("stall_valid", 64'(bus.mem_valid), 64'd1);
        check("stall_addr", 64'(bus.mem_addr), 64'(held.addr));
        check("stall_data", 64'(bus.mem_data), 64'(held.data));
        check("stall_pmask", 64'(bus.mem_pmask), 64'(held.pmask));
      end
      stalled = 1'b0;
      if (bus.mem_valid) begin
        wr.addr  = bus.mem_addr;
        wr.data  = bus.mem_data;
        wr.pmask = bus.mem_pmask;
        if (bus.mem_ready) got_q.push_back(wr);
        else begin
          stalled = 1'b1;
          held    = wr;
        end
      end
      if (bus.row_done) begin
        done_pulses++;
        got_done = j;
      end
    end
    check("done_cycle", 64'(got_done), 64'(exp_done));
    check("done_pulses", 64'(done_pulses), 64'd1);
    check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("wr_addr", 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check("wr_data", 64'(got_q[i].data), 64'(exp_q[i].data));
      check("wr_pmask", 64'(got_q[i].pmask), 64'(exp_q[i].pmask));
    end
  endtask

  initial begin
    logic [WARP_WIDTH-1:0] full;
    logic [WARP_WIDTH-1:0] m;
    logic [WORD_PIX-1:0]   sl;
    bit                    any_valid;

    full          = '1;
    rst           = 1'b1;
    bus.row_valid = 1'b0;
    bus.row_y     = '0;
    bus.row_mask  = '0;
    bus.row_color = '0;
    bus.mem_ready = 1'b0;

    #12;
    check("rst_row_ready", 64'(bus.row_ready), 64'd1);
    check("rst_mem_valid", 64'(bus.mem_valid), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_data", 64'(bus.mem_data), 64'd0);
    check("rst_mem_pmask", 64'(bus.mem_pmask), 64'd0);
    check("rst_row_done", 64'(bus.row_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full row at y=0, framebuffer always ready.
    run_row(10'd0, full, 4'hA, 0);
    check("full_row_done_k22", 64'(got_done), 64'd22);
    check("full_row_data", 64'((got_q.size() > 0) ? got_q[0].data : '0), 64'hAAAA_AAAA_AAAA_AAAA);

    // Coverage on pixels 17..40 only.
    m = '0;
    for (int i = 17; i <= 40; i++) m[i] = 1'b1;
    run_row(10'd3, m, 4'h5, 0);

    // First off-screen row: dropped entirely.
    run_row(10'd240, full, 4'hF, 0);
    check("dropped_row_writes", 64'(got_q.size()), 64'd0);

    // Framebuffer ready toggling every cycle.
    run_row(10'd10, full, 4'h7, 1);
    check("toggle_done_k42", 64'(got_done), 64'd42);

    // Reset while word 7 of row 5 is on the bus.
    wait_idle();
    bus.row_valid = 1'b1;
    bus.row_y     = 10'd5;
    bus.row_mask  = full;
    bus.row_color = 4'h3;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      bus.row_valid = 1'b0;
    end
    check("pre_reset_valid", 64'(bus.mem_valid), 64'd1);
    check("pre_reset_addr", 64'(bus.mem_addr), 64'd107);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(bus.mem_valid), 64'd0);
    check("async_rst_addr", 64'(bus.mem_addr), 64'd0);
    check("async_rst_ready", 64'(bus.row_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    any_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      any_valid |= bus.mem_valid;
    end
    check("abandoned_row_quiet", 64'(any_valid), 64'd0);
    check("ready_after_release", 64'(bus.row_ready), 64'd1);
    run_row(10'd6, full, 4'h6, 0);
    check("first_addr_y6", 64'((got_q.size() > 0) ? got_q[0].addr : '1), 64'd120);

    // Random rows, including off-screen ones and random backpressure.
    for (int r = 0; r < 12; r++) begin
      for (int w = 0; w < WORDS_PER_ROW; w++) begin
        case ($urandom_range(0, 3))
          0:       sl = '0;
          1:       sl = '1;
          default: sl = 16'($urandom);
        endcase
        m[w*WORD_PIX +: WORD_PIX] = sl;
      end
      run_row(10'($urandom_range(0, 259)), m, 4'($urandom), int'($urandom_range(0, 2)));
    end

    // Last on-screen row reaches the top framebuffer address.
    run_row(10'd239, full, 4'h1, 0);
    check("max_addr", 64'((got_q.size() > 0) ? got_q[got_q.size()-1].addr : '0), 64'd4799);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
